id_ex_stage: RTL
================

# id_ex_stage

Pipeline register between decode and the execute-stage ALU. It captures decoded instruction fields and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU operand and control inputs and detects load-use hazards, inserting one bubble and stalling decode.

## Interface
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_alu_control  in  4  ALU operation code (ALU encoding, e.g. 0010 ADD, 0110 SUB)
- id_op1_sel  in  2  00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero)
- id_op2_sel  in  1  0 rs2, 1 imm
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  kill the instruction entering EX this cycle (branch redirect)
- ex_stall  in  1  downstream cannot advance; hold EX contents
- exm_reg_write  in  1, exm_rd_addr  in  5, exm_result  in  XLEN  EX/MEM forward source
- wb_reg_write  in  1, wb_rd_addr  in  5, wb_result  in  XLEN  MEM/WB forward source
- ex_valid  out  1  EX holds a valid instruction
- ex_op1, ex_op2  out  XLEN  ALU operands (combinational from registers and forwarding)
- ex_alu_control  out  4  registered ALU code
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_pc  out  XLEN; ex_rd_addr  out  5; ex_reg_write, ex_mem_read, ex_mem_write  out  1
- stall_id  out  1  decode and fetch must hold

## Operation
- Registered fields: valid, pc, rs1/rs2 data, imm, addresses, uses flags, alu_control, op selects, control bits.
- Forwarding, per source operand, is combinational each cycle.
  - EX/MEM wins when exm_reg_write=1, exm_rd_addr≠0, and the address matches.
  - Otherwise MEM/WB wins when wb_reg_write=1, wb_rd_addr≠0, and the address matches.
  - Otherwise the registered data is used.
  - x0 is never forwarded.
- ex_op1 is the forwarded rs1, pc or 0, per op1_sel. ex_op2 is the forwarded rs2 or imm, per op2_sel. ex_store_data is always the forwarded rs2.
- Load-use is detected when all of the following hold:
  - ex_valid=1 and ex_mem_read=1 and ex_rd_addr≠0;
  - id_valid=1;
  - (id_uses_rs1 and id_rs1_addr=ex_rd_addr) or (id_uses_rs2 and id_rs2_addr=ex_rd_addr).
- stall_id = load_use | ex_stall.
- Register update priority per clock edge (highest first):
  1. flush: ex_valid←0 and control bits←0. Other fields don't care.
  2. ex_stall: hold all fields, but overwrite the rs1/rs2 data registers with the current forwarded values (operand refresh). A value retiring from WB during the stall is then not lost.
  3. load_use: insert a bubble (ex_valid←0, control bits←0). Decode holds, so the dependent instruction loads on the next cycle.
  4. Otherwise: load all fields from the id_* inputs. ex_valid←id_valid. Control bits are masked to 0 when id_valid=0.
- When ex_valid=0, ex_reg_write, ex_mem_read and ex_mem_write are 0. The operand outputs still evaluate but are don't care.

## Timing
- Reset (asynchronous, rst_n=0): every register is 0. So ex_valid=0, ex_alu_control=0000, ex_pc=0, ex_rd_addr=0, all control outputs 0, ex_op1=ex_op2=ex_store_data=0 (no forwarding matches, because rd registers are 0), and stall_id=0 unless ex_stall=1.
- Latency: one cycle from id_* to ex_*. Forwarding adds no cycles.
- A load followed by a dependent instruction costs exactly one bubble cycle. The value then comes from EX/MEM or MEM/WB forwarding.
- flush together with load_use: flush wins. stall_id still asserts that cycle from load_use, which is harmless because fetch redirects.
- flush together with ex_stall: flush wins and EX becomes empty.
- Reset asserted mid-stall: clears immediately. Release is synchronous to the next clk edge.

## Test plan
- Reset: hold rst_n=0 with id_valid=1 -> all ex_* outputs 0, ex_valid=0. Release, then ADD with rs1=5, rs2=7 (x1=5, x2=7) -> next cycle ex_op1=5, ex_op2=7, ex_alu_control=0010, ex_valid=1.
- Forward priority: EX holds rs1=x3 (reg data 1), exm writes x3=0xAA and wb writes x3=0xBB -> ex_op1=0xAA. Drop exm_reg_write -> 0xBB. Set rd=0 on both -> ex_op1=1.
- Load-use: LW x4 then ADD x5,x4,x4 -> stall_id=1 for one cycle, and the next EX cycle has ex_valid=0. The ADD then enters with exm_result=0x1234 forwarded to both operands.
- Operand refresh: ex_stall=1 for 3 cycles while wb writes rs2 reg x6=0x55 only in the first cycle -> after stall release, ex_op2 remains 0x55 with no forward active.
- Operand selects: AUIPC-style op1_sel=01, op2_sel=1, pc=0x100, imm=0x2000 -> ex_op1=0x100, ex_op2=0x2000. LUI op1_sel=10 -> ex_op1=0.
- Flush with ex_stall and load_use all asserted -> next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding,
// load-use bubble insertion and operand refresh while EX is stalled.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [3:0]      id_alu_control,
    input  logic [1:0]      id_op1_sel,
    input  logic            id_op2_sel,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd_addr,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [3:0]      ex_alu_control,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            stall_id
);
    logic [XLEN-1:0] rs1_data, rs2_data, imm, fwd_rs1, fwd_rs2;
    logic [4:0]      rs1_addr, rs2_addr;
    logic [1:0]      op1_sel;
    logic            op2_sel, load_use;

    // EX/MEM takes precedence over MEM/WB; x0 never matches
    always_comb begin
        fwd_rs1 = (exm_reg_write && exm_rd_addr != 5'd0 && exm_rd_addr == rs1_addr) ? exm_result :
                  (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == rs1_addr) ? wb_result : rs1_data;
        fwd_rs2 = (exm_reg_write && exm_rd_addr != 5'd0 && exm_rd_addr == rs2_addr) ? exm_result :
                  (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == rs2_addr) ? wb_result : rs2_data;
        ex_op1 = (op1_sel == 2'b00) ? fwd_rs1 : (op1_sel == 2'b01) ? ex_pc : '0;
        ex_op2 = op2_sel ? imm : fwd_rs2;
        ex_store_data = fwd_rs2;
        load_use = ex_valid && ex_mem_read && ex_rd_addr != 5'd0 && id_valid &&
                   ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        stall_id = load_use || ex_stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            rs1_data       <= '0;
            rs2_data       <= '0;
            imm            <= '0;
            rs1_addr       <= '0;
            rs2_addr       <= '0;
            ex_rd_addr     <= '0;
            ex_alu_control <= '0;
            op1_sel        <= '0;
            op2_sel        <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
        end else if (flush || (!ex_stall && load_use)) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (ex_stall) begin
            // keep a value that retires from WB during the stall
            rs1_data <= fwd_rs1;
            rs2_data <= fwd_rs2;
        end else begin
            ex_valid       <= id_valid;
            ex_pc          <= id_pc;
            rs1_data       <= id_rs1_data;
            rs2_data       <= id_rs2_data;
            imm            <= id_imm;
            rs1_addr       <= id_rs1_addr;
            rs2_addr       <= id_rs2_addr;
            ex_rd_addr     <= id_rd_addr;
            ex_alu_control <= id_alu_control;
            op1_sel        <= id_op1_sel;
            op2_sel        <= id_op2_sel;
            ex_reg_write   <= id_valid && id_reg_write;
            ex_mem_read    <= id_valid && id_mem_read;
            ex_mem_write   <= id_valid && id_mem_write;
        end
    end
endmodule
